// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter in front of the single-port data memory, with range check and 1-cycle responses.
// Optional DMEM_ARB_LOCK_EN adds per-port lock inputs for bounded exclusive ownership.
module dmem_arbiter #(
    parameter int MEM_SIZE   = 1024,
    parameter int XLEN       = 32,
    parameter int DATA_WIDTH = XLEN,
    parameter int MAX_LOCK   = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
`ifdef DMEM_ARB_LOCK_EN
    input  logic                             i_p0_lock,
    input  logic                             i_p1_lock,
`endif
    input  logic                             i_p0_req,
    input  logic                             i_p0_we,
    input  logic [XLEN-1:0]                  i_p0_addr,
    input  logic [DATA_WIDTH-1:0]            i_p0_wdata,
    input  logic [DATA_WIDTH/8-1:0]          i_p0_wstrb,
    output logic                             o_p0_gnt,
    output logic                             o_p0_rsp_valid,
    output logic [DATA_WIDTH-1:0]            o_p0_rdata,
    output logic                             o_p0_err,
    input  logic                             i_p1_req,
    input  logic                             i_p1_we,
    input  logic [XLEN-1:0]                  i_p1_addr,
    input  logic [DATA_WIDTH-1:0]            i_p1_wdata,
    input  logic [DATA_WIDTH/8-1:0]          i_p1_wstrb,
    output logic                             o_p1_gnt,
    output logic                             o_p1_rsp_valid,
    output logic [DATA_WIDTH-1:0]            o_p1_rdata,
    output logic                             o_p1_err,
    output logic                             o_mem_we,
    output logic [XLEN-1:0]                  o_mem_addr,
    output logic [DATA_WIDTH-1:0]            o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0]          o_mem_wstrb,
    input  logic [DATA_WIDTH-1:0]            i_mem_rdata
);
    localparam int BYTE_WIDTH = 8;
    localparam int NB         = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [XLEN:0] LIMIT   = (XLEN+1)'(MEM_SIZE * NB);
    localparam logic [XLEN:0] SPAN_M1 = (XLEN+1)'(NB - 1);

    logic                  last_gnt_q, last_gnt_d;
    logic                  p0_rsp_valid_q, p0_rsp_valid_d, p1_rsp_valid_q, p1_rsp_valid_d;
    logic                  p0_err_q, p0_err_d, p1_err_q, p1_err_d;
    logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
    logic                  p0_in_range, p1_in_range, pick1;

    // Extra top bit keeps an address near the top of XLEN from wrapping into range.
    assign p0_in_range = ({1'b0, i_p0_addr} + SPAN_M1) < LIMIT;
    assign p1_in_range = ({1'b0, i_p1_addr} + SPAN_M1) < LIMIT;

`ifdef DMEM_ARB_LOCK_EN
    logic       owned_q, owned_d, owner_q, owner_d, own_hold, g_lock;
    logic [2:0] cnt_q, cnt_d, cnt_n;

    assign own_hold = owned_q && (owner_q ? (i_p1_req && i_p1_lock) : (i_p0_req && i_p0_lock));
`endif

    always_comb begin
        // last_gnt names the port that lost priority; the other one wins a conflict.
        pick1 = !last_gnt_q;
`ifdef DMEM_ARB_LOCK_EN
        if (own_hold) pick1 = owner_q;
`endif
        o_p0_gnt = i_p0_req && (!i_p1_req || !pick1);
        o_p1_gnt = i_p1_req && (!i_p0_req || pick1);

        last_gnt_d = o_p1_gnt ? 1'b1 : (o_p0_gnt ? 1'b0 : last_gnt_q);

        o_mem_addr  = o_p1_gnt ? i_p1_addr  : i_p0_addr;
        o_mem_wdata = o_p1_gnt ? i_p1_wdata : i_p0_wdata;
        o_mem_wstrb = o_p1_gnt ? i_p1_wstrb : i_p0_wstrb;
        o_mem_we    = (o_p0_gnt && i_p0_we && p0_in_range) || (o_p1_gnt && i_p1_we && p1_in_range);

        p0_rsp_valid_d = o_p0_gnt;
        p0_err_d       = o_p0_gnt && !p0_in_range;
        p0_rdata_d     = (o_p0_gnt && !i_p0_we && p0_in_range) ? i_mem_rdata : '0;
        p1_rsp_valid_d = o_p1_gnt;
        p1_err_d       = o_p1_gnt && !p1_in_range;
        p1_rdata_d     = (o_p1_gnt && !i_p1_we && p1_in_range) ? i_mem_rdata : '0;
    end

`ifdef DMEM_ARB_LOCK_EN
    always_comb begin
        owned_d = owned_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        cnt_n   = own_hold ? cnt_q + 3'd1 : 3'd1;
        g_lock  = (o_p0_gnt && i_p0_lock) || (o_p1_gnt && i_p1_lock);
        if (owned_q && !own_hold) begin
            owned_d = 1'b0;
            cnt_d   = 3'd0;
        end
        // Expiry releases ownership; last_gnt then points at the old owner, so the other port wins next.
        if (g_lock) begin
            if (cnt_n >= 3'(MAX_LOCK)) begin
                owned_d = 1'b0;
                cnt_d   = 3'd0;
            end else begin
                owned_d = 1'b1;
                owner_d = o_p1_gnt;
                cnt_d   = cnt_n;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            owned_q <= 1'b0;
            owner_q <= 1'b0;
            cnt_q   <= 3'd0;
        end else begin
            owned_q <= owned_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_gnt_q     <= 1'b1;
            p0_rsp_valid_q <= 1'b0;
            p0_err_q       <= 1'b0;
            p0_rdata_q     <= '0;
            p1_rsp_valid_q <= 1'b0;
            p1_err_q       <= 1'b0;
            p1_rdata_q     <= '0;
        end else begin
            last_gnt_q     <= last_gnt_d;
            p0_rsp_valid_q <= p0_rsp_valid_d;
            p0_err_q       <= p0_err_d;
            p0_rdata_q     <= p0_rdata_d;
            p1_rsp_valid_q <= p1_rsp_valid_d;
            p1_err_q       <= p1_err_d;
            p1_rdata_q     <= p1_rdata_d;
        end
    end

    assign o_p0_rsp_valid = p0_rsp_valid_q;
    assign o_p0_err       = p0_err_q;
    assign o_p0_rdata     = p0_rdata_q;
    assign o_p1_rsp_valid = p1_rsp_valid_q;
    assign o_p1_err       = p1_err_q;
    assign o_p1_rdata     = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural memory (64 words, 256 bytes).
module tb_dmem_arbiter;
    localparam int MEM_SIZE = 64;

    logic        clk = 1'b0;
    logic        rst_n, init;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [3:0]  p0_wstrb, p1_wstrb;
    logic        p0_gnt, p0_rsp_valid, p0_err, p1_gnt, p1_rsp_valid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
`ifdef DMEM_ARB_LOCK_EN
    logic        p0_lock, p1_lock;
    logic [7:0]  pat;
`endif
    logic [31:0] mem [0:63];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_SIZE(MEM_SIZE), .XLEN(32), .DATA_WIDTH(32), .MAX_LOCK(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
`ifdef DMEM_ARB_LOCK_EN
        .i_p0_lock(p0_lock), .i_p1_lock(p1_lock),
`endif
        .i_p0_req(p0_req), .i_p0_we(p0_we), .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata),
        .i_p0_wstrb(p0_wstrb), .o_p0_gnt(p0_gnt), .o_p0_rsp_valid(p0_rsp_valid),
        .o_p0_rdata(p0_rdata), .o_p0_err(p0_err),
        .i_p1_req(p1_req), .i_p1_we(p1_we), .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata),
        .i_p1_wstrb(p1_wstrb), .o_p1_gnt(p1_gnt), .o_p1_rsp_valid(p1_rsp_valid),
        .o_p1_rdata(p1_rdata), .o_p1_err(p1_err),
        .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .o_mem_wstrb(mem_wstrb), .i_mem_rdata(mem_rdata)
    );

    // Memory starts as 0x1000_0000 + word index so reads are distinguishable.
    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end
    assign mem_rdata = mem[mem_addr[7:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_wstrb = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_wstrb = 0;
    endtask

    task automatic drv0(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        p0_req = 1; p0_we = we; p0_addr = a; p0_wdata = d; p0_wstrb = s;
    endtask

    task automatic drv1(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        p1_req = 1; p1_we = we; p1_addr = a; p1_wdata = d; p1_wstrb = s;
    endtask

    initial begin
        idle();
`ifdef DMEM_ARB_LOCK_EN
        p0_lock = 0; p1_lock = 0;
`endif
        rst_n = 0; init = 1;
        tick();
        init = 0;
        chk("rst_p0_rsp", 32'(p0_rsp_valid), 0);
        chk("rst_p1_rsp", 32'(p1_rsp_valid), 0);
        chk("rst_p0_rdata", p0_rdata, 0);
        chk("rst_p1_err", 32'(p1_err), 0);
        chk("rst_gnt", {30'd0, p1_gnt, p0_gnt}, 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        #2 rst_n = 1;

        // Conflict after reset: p0 first, then strict alternation.
        drv0(0, 32'h10, 0, 0); drv1(0, 32'h20, 0, 0);
        #1 chk("cf_a_gnt", {30'd0, p1_gnt, p0_gnt}, 32'b01);
        tick();
        chk("cf_a_rsp0", 32'(p0_rsp_valid), 1);
        chk("cf_a_rdata0", p0_rdata, 32'h1000_0004);
        chk("cf_a_rsp1", 32'(p1_rsp_valid), 0);
        chk("cf_b_gnt", {30'd0, p1_gnt, p0_gnt}, 32'b10);
        tick();
        chk("cf_b_rsp", {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'b10);
        chk("cf_b_rdata1", p1_rdata, 32'h1000_0008);
        chk("cf_c_gnt", {30'd0, p1_gnt, p0_gnt}, 32'b01);
        tick();
        chk("cf_c_rsp", {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'b01);
        chk("cf_d_gnt", {30'd0, p1_gnt, p0_gnt}, 32'b10);
        tick();
        chk("cf_d_rsp", {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'b10);

        // Single write then read back.
        idle(); drv0(1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        #1 chk("wr_gnt0", 32'(p0_gnt), 1);
        chk("wr_mem_we", 32'(mem_we), 1);
        chk("wr_mem_addr", mem_addr, 32'h10);
        chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        chk("wr_rsp0", 32'(p0_rsp_valid), 1);
        chk("wr_err0", 32'(p0_err), 0);
        chk("wr_rdata0", p0_rdata, 0);
        chk("wr_mem4", mem[4], 32'hDEAD_BEEF);
        drv0(0, 32'h10, 0, 0);
        #1 chk("rd_gnt0", 32'(p0_gnt), 1);
        chk("rd_mem_we", 32'(mem_we), 0);
        tick();
        chk("rd_rsp0", 32'(p0_rsp_valid), 1);
        chk("rd_rdata0", p0_rdata, 32'hDEAD_BEEF);
        drv0(0, 32'h14, 0, 0);
        tick();
        chk("b2b_rsp0", 32'(p0_rsp_valid), 1);
        chk("b2b_rdata0", p0_rdata, 32'h1000_0005);

        // Strobed write from p1.
        idle(); drv1(1, 32'h20, 32'hAAAA_AAAA, 4'hF);
        tick();
        drv1(1, 32'h20, 32'h1122_3344, 4'h3);
        #1 chk("sw_mem_wstrb", 32'(mem_wstrb), 32'h3);
        chk("sw_mem_addr", mem_addr, 32'h20);
        tick();
        chk("sw_rsp1", 32'(p1_rsp_valid), 1);
        chk("sw_err1", 32'(p1_err), 0);
        drv1(0, 32'h20, 0, 0);
        tick();
        chk("sw_rdata1", p1_rdata, 32'hAAAA_3344);

        // Out-of-range writes: wrap case and straddling the top.
        idle(); drv0(1, 32'hFFFF_FFFE, 32'h5555_5555, 4'hF);
        #1 chk("oor_wrap_gnt0", 32'(p0_gnt), 1);
        chk("oor_wrap_we", 32'(mem_we), 0);
        tick();
        chk("oor_wrap_rsp0", 32'(p0_rsp_valid), 1);
        chk("oor_wrap_err0", 32'(p0_err), 1);
        chk("oor_wrap_rdata0", p0_rdata, 0);
        drv0(1, MEM_SIZE * 4 - 2, 32'h5555_5555, 4'hF);
        #1 chk("oor_top_we", 32'(mem_we), 0);
        tick();
        chk("oor_top_err0", 32'(p0_err), 1);
        drv0(0, MEM_SIZE * 4 - 4, 0, 0);
        tick();
        chk("last_word_err0", 32'(p0_err), 0);
        chk("last_word_rdata0", p0_rdata, 32'h1000_003F);
        chk("oor_mem0", mem[0], 32'h1000_0000);

        // Reset right after a grant drops the pending response.
        drv0(0, 32'h10, 0, 0);
        tick();
        chk("ar_pre_rsp0", 32'(p0_rsp_valid), 1);
        idle();
        #1 rst_n = 0;
        #1 chk("ar_rsp0", 32'(p0_rsp_valid), 0);
        chk("ar_rdata0", p0_rdata, 0);
        #6 rst_n = 1;
        tick();
        chk("ar_post_rsp0", 32'(p0_rsp_valid), 0);
        tick();
        chk("ar_post_rsp", {30'd0, p1_rsp_valid, p0_rsp_valid}, 0);
        drv0(0, 32'h10, 0, 0); drv1(0, 32'h20, 0, 0);
        #1 chk("ar_cf_gnt", {30'd0, p1_gnt, p0_gnt}, 32'b01);
        tick();
        chk("ar_keep_write", p0_rdata, 32'hDEAD_BEEF);
        chk("ar_cf2_gnt", {30'd0, p1_gnt, p0_gnt}, 32'b10);
        tick();
        chk("ar_rdata1", p1_rdata, 32'hAAAA_3344);
        idle();
        tick();

`ifdef DMEM_ARB_LOCK_EN
        // p1 locks against a continuously requesting p0: 4 owned grants, then p0, then alternation.
        rst_n = 0;
        #2 rst_n = 1;
        drv0(0, 32'h10, 0, 0); drv1(0, 32'h20, 0, 0);
        p1_lock = 1;
        pat = 8'b0101_1110;
        for (int c = 0; c < 8; c++) begin
            #1 chk($sformatf("lock_c%0d_gnt", c), {30'd0, p1_gnt, p0_gnt}, {30'd0, pat[c], !pat[c]});
            tick();
            if (c == 5) p1_lock = 0;
        end
        idle();
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter in front of the single-port data memory.
- Requester 0 is the core load/store path; requester 1 is the DMA/debug port.
- Grants at most one access per cycle using round-robin priority, and blocks writes to out-of-range addresses.
- Drives memory address/write signals combinationally from the granted port, registers read data, and returns a one-cycle response pulse per accepted transaction.

Parameters:
- MEM_SIZE, DATA_MEM_SIZE, memory depth in words; legal byte addresses are 0 .. MEM_SIZE*(XLEN/BYTE_WIDTH)-1.
- DATA_WIDTH, XLEN, data bus width.
- MAX_LOCK, 4, maximum consecutive locked grants to one port (used only with the optional feature).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_pN_req  in  1  request, N = 0,1.
- i_pN_we  in  1  1 = write, 0 = read.
- i_pN_addr  in  XLEN  byte address.
- i_pN_wdata  in  DATA_WIDTH  write data.
- i_pN_wstrb  in  DATA_WIDTH/BYTE_WIDTH  byte strobes.
- o_pN_gnt  out  1  request accepted this cycle (combinational).
- o_pN_rsp_valid  out  1  response pulse, one cycle after grant.
- o_pN_rdata  out  DATA_WIDTH  registered read data, valid while rsp_valid is high.
- o_pN_err  out  1  address out of range, valid while rsp_valid is high.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  XLEN  memory address.
- o_mem_wdata  out  DATA_WIDTH  memory write data.
- o_mem_wstrb  out  DATA_WIDTH/BYTE_WIDTH  memory strobes.
- i_mem_rdata  in  DATA_WIDTH  combinational memory read data.

Behaviour:
- Reset (async, immediate):
  - rsp_valid = 0, rdata = 0, err = 0 on both ports.
  - last_gnt = 1, so port 0 wins the first conflict.
  - Lock state cleared.
  - gnt and mem outputs are combinational; with no requests they are 0.
- Grant rules:
  - Only one requester: it is granted the same cycle.
  - Both request: the port not equal to last_gnt is granted.
  - last_gnt updates on every posedge where a grant occurs and holds otherwise.
  - A transaction is accepted when req && gnt at a posedge.
  - Requesters hold req and all payload stable until gnt.
- Memory drive:
  - o_mem_addr, o_mem_wdata, o_mem_wstrb mux from the granted port; port 0 payload when idle.
  - o_mem_we = gnt && we && in_range.
  - A write lands in memory at the posedge of the grant cycle.
- Range check: in_range = addr + DATA_WIDTH/BYTE_WIDTH - 1 < MEM_SIZE*(DATA_WIDTH/BYTE_WIDTH). Compute it in XLEN+1 bits so wrap-around can never pass the check.
- Response:
  - The cycle after acceptance, o_pN_rsp_valid = 1 for exactly one cycle, for both reads and writes.
  - o_pN_err = !in_range of the accepted request.
  - o_pN_rdata = i_mem_rdata sampled at the grant posedge for an in-range read; 0 for writes or errors.
  - Read latency is 1 cycle.
- Back-to-back traffic: one port can be granted on consecutive cycles if the other is idle. Each response pulse is independent, so rsp_valid can stay high for consecutive cycles.
- Simultaneous events: a grant and the response to the previous grant occur in the same cycle without conflict. Response registers are per port.
- Reset mid-transaction: a pending response is dropped (no pulse after reset release). A write already clocked into memory is not undone.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- Enabled:
  - Adds inputs i_p0_lock and i_p1_lock (1 bit each).
  - A grant with lock=1 makes that port owner; the owner wins all conflicts on following cycles.
  - A 3-bit lock counter counts consecutive owner grants.
  - Ownership ends when the owner presents req with lock=0, drops req, or completes MAX_LOCK grants.
  - After a MAX_LOCK expiry, if the other port is requesting it must be granted next; this is forced fairness.
  - Reset clears owner and counter.
- Disabled: lock ports are absent and arbitration is pure round-robin.

Test Plan:
- Single read: write 0xDEADBEEF at 0x10 via p0 (wstrb 0xF), then p0 reads 0x10 → p0_gnt the same cycle; next cycle p0_rsp_valid=1, p0_rdata=0xDEADBEEF, p0_err=0.
- Conflict after reset: p0 and p1 both read on every cycle, back to back → grants alternate p0, p1, p0, p1; each rsp_valid lands one cycle after its own grant.
- Strobed write: p1 writes 0x11223344 at 0x20 with wstrb 0x3 over prior 0xAAAAAAAA → a read returns 0xAAAA3344.
- Out-of-range: p0 writes at address 0xFFFFFFFE (wrap case) and at MEM_SIZE*4-2 → o_mem_we stays 0; rsp pulses with err=1; memory unchanged.
- Async reset: assert i_rst_n low mid-cycle, right after a grant → rsp_valid drops immediately and no pulse appears after release; the next conflict grants p0 first.
- Lock (DMEM_ARB_LOCK_EN, MAX_LOCK=4): p1 locks while p0 requests continuously → p1 gets 4 grants, then p0 is granted, then normal alternation resumes.
